// File: rtl/spi_wb_bridge_pkg.sv
// Shared constants and state types for the SPI-to-Wishbone bridge.
package spi_wb_bridge_pkg;

   localparam logic [7:0] CMD_WRITE   = 8'h02;
   localparam logic [7:0] CMD_READ    = 8'h03;

   // Byte indices within a frame; byte 0 is the command byte.
   localparam logic [3:0] ADDR_LAST   = 4'd4;
   localparam logic [3:0] WDATA_LAST  = 4'd8;
   localparam logic [3:0] DUMMY_BYTE  = 4'd5;
   localparam logic [3:0] RDATA_FIRST = 4'd6;
   localparam logic [3:0] RDATA_LAST  = 4'd9;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WDATA,
      DUMMY,
      RDATA,
      IGNORE
   } spi_state_t;

   typedef enum logic {
      WB_IDLE,
      WB_BUSY
   } wb_state_t;

   function automatic logic is_valid_cmd(input logic [7:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_READ);
   endfunction

endpackage

// File: rtl/spi_wb_bridge_if.sv
// Wishbone master bus of the bridge, bundled so the bridge and the slave share one port.
interface spi_wb_bridge_if;

   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i
   );

endinterface

// File: rtl/spi_sync.sv
// Brings the asynchronous SPI host lines into the clk domain and derives edge strobes.
module spi_sync (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic ssn,
   input  logic mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ssn_rise,
   output logic ssn_fall,
   output logic ssn_sync,
   output logic mosi_sync
);

   logic sck_meta, sck_sync, sck_dly;
   logic ssn_meta, ssn_dly;
   logic mosi_meta;

   // Reset values match an idle bus: slave deselected, clock low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_meta  <= 1'b0;
         sck_sync  <= 1'b0;
         sck_dly   <= 1'b0;
         ssn_meta  <= 1'b1;
         ssn_sync  <= 1'b1;
         ssn_dly   <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         sck_meta  <= sck;
         sck_sync  <= sck_meta;
         sck_dly   <= sck_sync;
         ssn_meta  <= ssn;
         ssn_sync  <= ssn_meta;
         ssn_dly   <= ssn_sync;
         mosi_meta <= mosi;
         mosi_sync <= mosi_meta;
      end
   end

   assign sck_rise = sck_sync & ~sck_dly;
   assign sck_fall = ~sck_sync & sck_dly;
   assign ssn_rise = ssn_sync & ~ssn_dly;
   assign ssn_fall = ~ssn_sync & ssn_dly;

endmodule

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave that turns WRITE/READ command frames into single Wishbone cycles.
module spi_wb_bridge
   import spi_wb_bridge_pkg::*;
#(
   parameter int          CLK_DIV_MIN = 8,
   parameter logic [31:0] ADR_MASK    = 32'hFFFFFFFC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            spi_sck,
   input  logic            spi_ssn,
   input  logic            spi_mosi,
   output logic            spi_miso,
   output logic            spi_miso_oe,
   output logic            busy,
   spi_wb_bridge_if.master wb
);

   if (CLK_DIV_MIN < 4) begin : g_clk_div_check
      $error("spi_wb_bridge: CLK_DIV_MIN below 4 cannot be tracked by the synchronizers");
   end

   logic sck_rise, sck_fall, ssn_rise, ssn_fall, ssn_sync, mosi_sync;

   spi_state_t  state, state_nxt;
   wb_state_t   wb_state, wb_state_nxt;

   logic [2:0]  bit_cnt;
   logic [3:0]  byte_cnt;
   logic [6:0]  cmd_sr;
   logic [7:0]  cmd_byte;
   logic        is_write;
   logic [31:0] adr_reg;
   logic [30:0] wdat_reg;
   logic [31:0] tx_sr;
   logic [31:0] tx_word;
   logic [31:0] rd_word;
   logic        rd_pending;
   logic        rd_ready;

   logic        active;
   logic        byte_done;
   logic        wr_req;
   logic        rd_req;
   logic [31:0] req_adr;
   logic [31:0] req_dat;

   spi_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .sck       (spi_sck),
      .ssn       (spi_ssn),
      .mosi      (spi_mosi),
      .sck_rise  (sck_rise),
      .sck_fall  (sck_fall),
      .ssn_rise  (ssn_rise),
      .ssn_fall  (ssn_fall),
      .ssn_sync  (ssn_sync),
      .mosi_sync (mosi_sync)
   );

   assign active    = state inside {CMD, ADDR, WDATA, DUMMY, RDATA};
   assign byte_done = active && sck_rise && (bit_cnt == 3'd7);
   assign cmd_byte  = {cmd_sr, mosi_sync};

   // Requests fire on the rising edge of the final bit, so that bit comes straight from MOSI.
   assign wr_req  = (state == WDATA) && byte_done && (byte_cnt == WDATA_LAST) && !ssn_rise;
   assign rd_req  = (state == ADDR) && byte_done && (byte_cnt == ADDR_LAST) && !is_write && !ssn_rise;
   assign req_adr = wr_req ? adr_reg : {adr_reg[30:0], mosi_sync};
   assign req_dat = wr_req ? {wdat_reg, mosi_sync} : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (ssn_rise) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:   if (ssn_fall) state_nxt = CMD;
            CMD:    if (byte_done) state_nxt = is_valid_cmd(cmd_byte) ? ADDR : IGNORE;
            ADDR:   if (byte_done && (byte_cnt == ADDR_LAST)) state_nxt = is_write ? WDATA : DUMMY;
            WDATA:  if (byte_done && (byte_cnt == WDATA_LAST)) state_nxt = IGNORE;
            DUMMY:  if (byte_done && (byte_cnt == DUMMY_BYTE)) state_nxt = RDATA;
            RDATA:  if (byte_done && (byte_cnt == RDATA_LAST)) state_nxt = IGNORE;
            IGNORE: state_nxt = IGNORE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt  <= 3'd0;
         byte_cnt <= 4'd0;
      end else if (ssn_fall) begin
         bit_cnt  <= 3'd0;
         byte_cnt <= 4'd0;
      end else if (active && sck_rise) begin
         bit_cnt <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) begin
            byte_cnt <= byte_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_sr   <= 7'h0;
         adr_reg  <= 32'h0;
         wdat_reg <= 31'h0;
         is_write <= 1'b0;
      end else if (sck_rise) begin
         case (state)
            CMD: begin
               cmd_sr <= cmd_byte[6:0];
               if (bit_cnt == 3'd7) begin
                  is_write <= (cmd_byte == CMD_WRITE);
               end
            end
            ADDR:    adr_reg  <= {adr_reg[30:0], mosi_sync};
            WDATA:   wdat_reg <= {wdat_reg[29:0], mosi_sync};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_state <= WB_IDLE;
      end else begin
         wb_state <= wb_state_nxt;
      end
   end

   // Requests seen while a cycle is still outstanding are simply dropped.
   always_comb begin
      wb_state_nxt = wb_state;
      case (wb_state)
         WB_IDLE: if (wr_req || rd_req) wb_state_nxt = WB_BUSY;
         WB_BUSY: if (wb.wb_ack_i) wb_state_nxt = WB_IDLE;
         default: wb_state_nxt = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb.wb_cyc_o <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_we_o  <= 1'b0;
         wb.wb_sel_o <= 4'h0;
         wb.wb_adr_o <= 32'h0;
         wb.wb_dat_o <= 32'h0;
      end else if ((wb_state == WB_IDLE) && (wr_req || rd_req)) begin
         wb.wb_cyc_o <= 1'b1;
         wb.wb_stb_o <= 1'b1;
         wb.wb_we_o  <= wr_req;
         wb.wb_sel_o <= 4'hF;
         wb.wb_adr_o <= req_adr & ADR_MASK;
         wb.wb_dat_o <= req_dat;
      end else if ((wb_state == WB_BUSY) && wb.wb_ack_i) begin
         wb.wb_cyc_o <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_we_o  <= 1'b0;
      end
   end

   assign busy = (wb_state == WB_BUSY);

   // Read data only counts if its frame is still open; an abort leaves the cycle to finish unheard.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pending <= 1'b0;
         rd_ready   <= 1'b0;
         rd_word    <= 32'h0;
      end else if (ssn_fall || ssn_rise) begin
         rd_pending <= 1'b0;
         rd_ready   <= 1'b0;
      end else begin
         if (rd_req && (wb_state == WB_IDLE)) begin
            rd_pending <= 1'b1;
         end
         if ((wb_state == WB_BUSY) && wb.wb_ack_i && rd_pending) begin
            rd_word    <= wb.wb_dat_i;
            rd_ready   <= 1'b1;
            rd_pending <= 1'b0;
         end
      end
   end

   assign tx_word = rd_ready ? rd_word : 32'hFFFFFFFF;

   // The word is latched on the sck fall that ends the dummy byte, putting bit 31 out ahead of the first rise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spi_miso <= 1'b0;
         tx_sr    <= 32'h0;
      end else if (ssn_fall || ssn_rise) begin
         spi_miso <= 1'b0;
      end else if (sck_fall) begin
         if (state == RDATA) begin
            if ((byte_cnt == RDATA_FIRST) && (bit_cnt == 3'd0)) begin
               spi_miso <= tx_word[31];
               tx_sr    <= {tx_word[30:0], 1'b0};
            end else begin
               spi_miso <= tx_sr[31];
               tx_sr    <= {tx_sr[30:0], 1'b0};
            end
         end else begin
            spi_miso <= 1'b0;
         end
      end
   end

   assign spi_miso_oe = ~ssn_sync;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge: SPI host driver, Wishbone slave model and expectation queues.
module tb_spi_wb_bridge;
   import spi_wb_bridge_pkg::*;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
   } wb_txn_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic spi_sck = 1'b0;
   logic spi_ssn = 1'b1;
   logic spi_mosi = 1'b0;
   logic spi_miso, spi_miso_oe, busy;

   int checks = 0;
   int errors = 0;
   int wb_cycles = 0;
   int ack_delay = 2;
   logic [31:0] slave_rdata = 32'h0;

   wb_txn_t    exp_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] miso_q[$];

   spi_wb_bridge_if wb ();

   spi_wb_bridge #(
      .CLK_DIV_MIN (8),
      .ADR_MASK    (32'hFFFFFFFC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_sck     (spi_sck),
      .spi_ssn     (spi_ssn),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .busy        (busy),
      .wb          (wb)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkOutput(tag, {31'h0, observed}, {31'h0, expected});
   endtask

   task automatic queueByte(input logic [7:0] tx, input logic [7:0] rx_exp);
      tx_q.push_back(tx);
      miso_q.push_back(rx_exp);
   endtask

   task automatic expectTxn(input logic [31:0] adr, input logic [31:0] dat, input logic we);
      wb_txn_t t;
      t.adr = adr;
      t.dat = dat;
      t.we  = we;
      exp_q.push_back(t);
   endtask

   // Mode 0 at clk/8: MOSI changes with the falling sck, MISO is read just before the rise.
   task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         repeat (4) @(negedge clk);
         rx[i] = spi_miso;
         spi_sck = 1'b1;
         repeat (4) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic runFrame(input bit close_frame);
      logic [7:0] b;
      logic [7:0] rx;
      logic [7:0] ex;
      @(negedge clk);
      spi_ssn = 1'b0;
      repeat (4) @(negedge clk);
      checkBit("miso_oe_active", spi_miso_oe, 1'b1);
      while (tx_q.size() > 0) begin
         b  = tx_q.pop_front();
         ex = miso_q.pop_front();
         applyStimulus(b, rx);
         checkOutput("miso_byte", {24'h0, rx}, {24'h0, ex});
      end
      if (close_frame) begin
         repeat (4) @(negedge clk);
         spi_ssn = 1'b1;
         repeat (4) @(negedge clk);
         checkBit("miso_oe_idle", spi_miso_oe, 1'b0);
         checkBit("miso_idle", spi_miso, 1'b0);
      end
   endtask

   task automatic waitIdle();
      for (int k = 0; k < 400 && busy; k++) @(negedge clk);
      checkBit("wb_idle", busy, 1'b0);
   endtask

   // Wishbone slave: pops the expected transaction when a cycle opens, acks after ack_delay clocks.
   initial begin
      wb_txn_t e;
      wb.wb_ack_i = 1'b0;
      wb.wb_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         if (rst && wb.wb_cyc_o && wb.wb_stb_o) begin
            wb_cycles++;
            checkOutput("wb_sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("wb_adr", wb.wb_adr_o, e.adr);
               checkBit("wb_we", wb.wb_we_o, e.we);
               checkOutput("wb_sel", {28'h0, wb.wb_sel_o}, 32'h0000000F);
               if (e.we) checkOutput("wb_dat", wb.wb_dat_o, e.dat);
            end
            for (int k = 0; k < ack_delay && wb.wb_cyc_o; k++) @(negedge clk);
            if (wb.wb_cyc_o) begin
               checkBit("wb_busy_during", busy, 1'b1);
               wb.wb_dat_i = slave_rdata;
               wb.wb_ack_i = 1'b1;
               @(negedge clk);
               wb.wb_ack_i = 1'b0;
               wb.wb_dat_i = 32'h0;
               checkBit("wb_cyc_drop", wb.wb_cyc_o, 1'b0);
               checkBit("wb_stb_drop", wb.wb_stb_o, 1'b0);
               checkBit("wb_busy_drop", busy, 1'b0);
            end
         end
      end
   end

   initial begin
      logic [7:0] wr_frame [9];
      logic [7:0] rd_hdr [5];
      wr_frame = '{CMD_WRITE, 8'h00, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      rd_hdr   = '{CMD_READ, 8'h40, 8'h00, 8'h00, 8'h04};

      $display("[TB] reset state");
      repeat (3) @(negedge clk);
      checkBit("rst_cyc", wb.wb_cyc_o, 1'b0);
      checkBit("rst_stb", wb.wb_stb_o, 1'b0);
      checkBit("rst_busy", busy, 1'b0);
      checkBit("rst_miso_oe", spi_miso_oe, 1'b0);
      checkBit("rst_miso", spi_miso, 1'b0);
      checkOutput("rst_adr", wb.wb_adr_o, 32'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] write frame");
      ack_delay = 2;
      expectTxn(32'h00000100, 32'hDEADBEEF, 1'b1);
      for (int i = 0; i < 9; i++) queueByte(wr_frame[i], 8'h00);
      runFrame(1'b1);
      waitIdle();

      $display("[TB] read frame, fast slave");
      ack_delay = 3;
      slave_rdata = 32'h12345678;
      expectTxn(32'h40000004, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) queueByte(rd_hdr[i], 8'h00);
      queueByte(8'h00, 8'h00);
      queueByte(8'h00, 8'h12);
      queueByte(8'h00, 8'h34);
      queueByte(8'h00, 8'h56);
      queueByte(8'h00, 8'h78);
      runFrame(1'b1);
      waitIdle();

      $display("[TB] read frame, slow slave");
      ack_delay = 100;
      slave_rdata = 32'hA5A50F0F;
      expectTxn(32'h40000004, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) queueByte(rd_hdr[i], 8'h00);
      queueByte(8'h00, 8'h00);
      for (int i = 0; i < 4; i++) queueByte(8'h00, 8'hFF);
      runFrame(1'b1);
      waitIdle();
      checkOutput("cycles_after_reads", wb_cycles, 32'd3);

      $display("[TB] aborted write, then masked write with trailing byte");
      ack_delay = 2;
      for (int i = 0; i < 6; i++) queueByte(wr_frame[i], 8'h00);
      runFrame(1'b1);
      repeat (20) @(negedge clk);
      checkBit("abort_no_cyc", wb.wb_cyc_o, 1'b0);
      checkOutput("abort_cycles", wb_cycles, 32'd3);
      expectTxn(32'h00000210, 32'hCAFEBABE, 1'b1);
      queueByte(CMD_WRITE, 8'h00);
      queueByte(8'h00, 8'h00);
      queueByte(8'h00, 8'h00);
      queueByte(8'h02, 8'h00);
      queueByte(8'h13, 8'h00);
      queueByte(8'hCA, 8'h00);
      queueByte(8'hFE, 8'h00);
      queueByte(8'hBA, 8'h00);
      queueByte(8'hBE, 8'h00);
      queueByte(8'hA5, 8'h00);
      runFrame(1'b1);
      waitIdle();
      checkOutput("masked_write_cycles", wb_cycles, 32'd4);

      $display("[TB] bad command");
      queueByte(8'h55, 8'h00);
      for (int i = 1; i < 9; i++) queueByte(wr_frame[i], 8'h00);
      runFrame(1'b1);
      repeat (20) @(negedge clk);
      checkOutput("bad_cmd_cycles", wb_cycles, 32'd4);

      $display("[TB] async reset mid read");
      ack_delay = 1000;
      expectTxn(32'h40000004, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) queueByte(rd_hdr[i], 8'h00);
      runFrame(1'b0);
      for (int k = 0; k < 20 && !wb.wb_cyc_o; k++) @(negedge clk);
      checkBit("pre_rst_cyc", wb.wb_cyc_o, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkBit("async_rst_cyc", wb.wb_cyc_o, 1'b0);
      checkBit("async_rst_stb", wb.wb_stb_o, 1'b0);
      checkBit("async_rst_we", wb.wb_we_o, 1'b0);
      checkBit("async_rst_busy", busy, 1'b0);
      checkOutput("async_rst_adr", wb.wb_adr_o, 32'h0);
      checkOutput("async_rst_sel", {28'h0, wb.wb_sel_o}, 32'h0);
      checkBit("async_rst_miso", spi_miso, 1'b0);
      checkBit("async_rst_oe", spi_miso_oe, 1'b0);
      @(negedge clk);
      spi_ssn = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      checkBit("post_rst_cyc", wb.wb_cyc_o, 1'b0);

      checkOutput("total_cycles", wb_cycles, 32'd5);
      checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
